// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: shared types and the burst index incrementer for the
// Wishbone burst block-RAM slave.
//   cti_t      : Wishbone cycle type identifiers recognised by the slave
//   bte_t      : Wishbone burst type extension (linear / wrap-4/8/16)
//   state_t    : read FSM states
//   next_index : next word index of a burst for a given burst type
package wb_bram_pkg;

  // Widest word index the helper handles; callers cast to their own width.
  localparam int unsigned IDX_MAX = 32;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    INCR    = 3'b010,
    END     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_CLASSIC,
    RD_BURST
  } state_t;

  // Wrapping bursts keep the upper index bits and only count in the low
  // 2/3/4 bits; linear bursts wrap at memory top through caller truncation.
  function automatic logic [IDX_MAX-1:0] next_index(input logic [IDX_MAX-1:0] index,
                                                    input bte_t              bte);
    logic [IDX_MAX-1:0] inc;
    logic [IDX_MAX-1:0] res;
    inc = index + IDX_MAX'(1);
    case (bte)
      WRAP4:   res = {index[IDX_MAX-1:2], inc[1:0]};
      WRAP8:   res = {index[IDX_MAX-1:3], inc[2:0]};
      WRAP16:  res = {index[IDX_MAX-1:4], inc[3:0]};
      default: res = inc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bram_be_sp.sv
// bram_be_sp: single-port RAM with per-byte write enables and a registered
// read port. Array contents are never reset; only the read register is.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset of the read register
//   en    : port enable
//   we    : write (1) / read (0) when enabled
//   be    : byte-lane write enables
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, updated only on enabled reads
module bram_be_sp #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_WIDTH/8-1:0]  be,
  input  logic [MEM_ADR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int unsigned DEPTH = 2 ** MEM_ADR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Holds its value between reads so a stalled burst keeps presenting the
  // pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone slave in front of a byte-enable block RAM with
// registered-feedback burst support (linear and wrap-4/8/16).
//   clk, rst_n : clock, asynchronous active-low reset
//   cyc, stb   : bus cycle / strobe
//   we         : write enable
//   adr        : byte address (bits above the word field must be zero)
//   sel        : byte lanes for writes (ignored on reads)
//   dat_ms     : write data
//   cti, bte   : cycle type, burst type
//   dat_sm     : registered read data, valid while ack=1
//   ack, err   : acknowledge, error acknowledge (never both)
// Writes acknowledge combinationally; reads acknowledge one cycle after the
// first strobe and then every cycle while a burst keeps stb high.
module wb_bram_burst
  import wb_bram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(SEL_WIDTH);
  localparam int TOP       = LSB + MEM_ADR_WIDTH;

  state_t                   state;
  logic                     ack_r;
  logic                     err_r;
  logic                     wr_cont;
  logic [MEM_ADR_WIDTH-1:0] idx;
  logic [MEM_ADR_WIDTH-1:0] adr_idx;
  logic [MEM_ADR_WIDTH-1:0] wr_idx;
  logic [MEM_ADR_WIDTH-1:0] wr_next;
  logic [MEM_ADR_WIDTH-1:0] rd_next;
  logic [MEM_ADR_WIDTH-1:0] rd_addr;
  logic [MEM_ADR_WIDTH-1:0] ram_addr;
  logic                     in_range;
  logic                     cti_incr;
  logic                     rd_req;
  logic                     wr_req;
  logic                     wr_ok;
  logic                     rd_issue;
  logic                     ram_en;

  assign adr_idx  = adr[TOP-1:LSB];
  assign in_range = ((adr >> TOP) == '0);
  assign cti_incr = (cti == INCR);
  assign rd_req   = cyc & stb & ~we;
  assign wr_req   = cyc & stb & we;
  assign wr_ok    = wr_req & in_range & rst_n;

  // Write bursts follow the internal index; adr is only used on a first beat.
  assign wr_idx  = wr_cont ? idx : adr_idx;
  assign wr_next = MEM_ADR_WIDTH'(next_index(IDX_MAX'(wr_idx), bte_t'(bte)));
  assign rd_next = MEM_ADR_WIDTH'(next_index(IDX_MAX'(idx), bte_t'(bte)));

  always_comb begin
    rd_issue = 1'b0;
    rd_addr  = adr_idx;
    if (state == IDLE && rd_req && in_range) begin
      rd_issue = 1'b1;
    end else if (state == RD_BURST && rd_req && cti_incr) begin
      rd_issue = 1'b1;
      rd_addr  = rd_next;
    end
    ram_en   = rd_issue | wr_ok;
    ram_addr = wr_ok ? wr_idx : rd_addr;
  end

  // Read ack/err are held in registers and qualified by the live strobe, so
  // a burst stalled by stb low shows no ack and resumes with the pending word.
  assign ack = wr_ok | (ack_r & rd_req);
  assign err = (wr_req & ~in_range & rst_n) | (err_r & rd_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      idx     <= '0;
      wr_cont <= 1'b0;
    end else begin
      if (wr_req) begin
        if (wr_ok && cti_incr) begin
          wr_cont <= 1'b1;
          idx     <= wr_next;
        end else begin
          wr_cont <= 1'b0;
        end
      end else if (!cyc) begin
        wr_cont <= 1'b0;
      end

      case (state)
        IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (rd_req) begin
            wr_cont <= 1'b0;
            if (in_range) begin
              idx   <= adr_idx;
              ack_r <= 1'b1;
              state <= cti_incr ? RD_BURST : RD_CLASSIC;
            end else begin
              // Error beat reuses the single-ack state to return to IDLE.
              err_r <= 1'b1;
              state <= RD_CLASSIC;
            end
          end
        end
        RD_CLASSIC: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          state <= IDLE;
        end
        RD_BURST: begin
          if (!cyc || wr_req) begin
            ack_r <= 1'b0;
            state <= IDLE;
          end else if (rd_req) begin
            // Any non-incrementing cycle type closes the burst on this beat.
            if (cti_incr) begin
              idx <= rd_next;
            end else begin
              ack_r <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  bram_be_sp #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MEM_ADR_WIDTH (MEM_ADR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (wr_ok),
    .be    (sel),
    .addr  (ram_addr),
    .wdata (dat_ms),
    .rdata (dat_sm)
  );

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed self-checking bench for wb_bram_burst (default parameters).
module tb_wb_bram_burst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [2048];
  int unsigned seq [8];

  always #5 clk = ~clk;

  wb_bram_burst #(
    .DATA_WIDTH    (32),
    .MEM_ADR_WIDTH (11),
    .ADR_WIDTH     (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cyc    (cyc),
    .stb    (stb),
    .we     (we),
    .adr    (adr),
    .sel    (sel),
    .dat_ms (dat_ms),
    .cti    (cti),
    .bte    (bte),
    .dat_sm (dat_sm),
    .ack    (ack),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat_ms = '0; cti = '0; bte = '0;
  endtask

  // Single classic write; updates the memory model for in-range addresses.
  task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cyc = 1; stb = 1; we = 1; adr = a; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
    @(negedge clk);
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_err"}, err, 0);
    nxt();
    idle_bus();
    for (int l = 0; l < 4; l++) begin
      if (s[l]) model[a[12:2]][8*l +: 8] = d[8*l +: 8];
    end
  endtask

  // Classic read; stb stays high one cycle after the ack to show ack drops.
  task automatic rd_classic(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF; cti = 3'b000; bte = 2'b00;
    @(negedge clk);
    chk({tag, "_wait"}, ack, 0);
    nxt();
    @(negedge clk);
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_data"}, dat_sm, exp);
    nxt();
    @(negedge clk);
    chk({tag, "_drop"}, ack, 0);
    nxt();
    idle_bus();
    nxt();
  endtask

  // Read burst of n beats following seq[]; last beat carries cti=111.
  task automatic rd_burst(input string tag, input int unsigned start, input logic [1:0] b,
                          input int unsigned n);
    cyc = 1; stb = 1; we = 0; adr = start * 4; sel = 4'hF; cti = 3'b010; bte = b;
    @(negedge clk);
    chk({tag, "_first"}, ack, 0);
    nxt();
    for (int unsigned k = 0; k < n; k++) begin
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
      chk($sformatf("%s_ack%0d", tag, k), ack, 1);
      chk($sformatf("%s_dat%0d", tag, k), dat_sm, model[seq[k]]);
      nxt();
    end
    idle_bus();
    @(negedge clk);
    chk({tag, "_end"}, ack, 0);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle_bus();
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", dat_sm, 0);
    nxt();
    rst_n = 1;

    // Preload words 0..15 with a recognisable pattern.
    for (int i = 0; i < 16; i++) wb_write("preload", i * 4, 32'hC0DE_0000 + i, 4'hF);

    // Classic write then read back.
    wb_write("w25", 32'h10, 32'hDEADBEEF, 4'hF);
    rd_classic("r25", 32'h10, 32'hDEADBEEF);

    // Byte lanes, then an all-lanes-off write that must change nothing.
    wb_write("w26a", 32'h10, 32'h11223344, 4'hF);
    wb_write("w26b", 32'h10, 32'hAABBCCDD, 4'b0101);
    rd_classic("r26", 32'h10, 32'h11BB33DD);
    wb_write("wsel0", 32'h10, 32'h99999999, 4'b0000);
    rd_classic("rsel0", 32'h10, 32'h11BB33DD);

    // Linear burst 5,6,7,8.
    seq = '{5, 6, 7, 8, 0, 0, 0, 0};
    rd_burst("lin", 5, 2'b00, 4);

    // Same burst with stb dropped for two cycles after beat 2.
    cyc = 1; stb = 1; we = 0; adr = 32'h14; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    @(negedge clk); chk("stall_first", ack, 0); nxt();
    @(negedge clk); chk("stall_ack0", ack, 1); chk("stall_dat0", dat_sm, 32'hC0DE_0005); nxt();
    @(negedge clk); chk("stall_ack1", ack, 1); chk("stall_dat1", dat_sm, 32'hC0DE_0006); nxt();
    stb = 0;
    @(negedge clk); chk("stall_gap0", ack, 0); nxt();
    @(negedge clk); chk("stall_gap1", ack, 0); nxt();
    stb = 1;
    @(negedge clk); chk("stall_ack2", ack, 1); chk("stall_dat2", dat_sm, 32'hC0DE_0007); nxt();
    cti = 3'b111;
    @(negedge clk); chk("stall_ack3", ack, 1); chk("stall_dat3", dat_sm, 32'hC0DE_0008); nxt();
    idle_bus();
    @(negedge clk); chk("stall_end", ack, 0); nxt();

    // Wrap-4 from 6 and wrap-8 from 13.
    seq = '{6, 7, 4, 5, 0, 0, 0, 0};
    rd_burst("wrap4", 6, 2'b01, 4);
    seq = '{13, 14, 15, 8, 9, 10, 11, 12};
    rd_burst("wrap8", 13, 2'b10, 8);

    // Linear burst across the top of memory.
    wb_write("wtop", 32'h1FFC, 32'hFEED_07FF, 4'hF);
    seq = '{2047, 0, 0, 0, 0, 0, 0, 0};
    rd_burst("top", 2047, 2'b00, 2);

    // Wrap-4 write burst from index 2 with adr held: lands on 2,3,0,1.
    for (int k = 0; k < 4; k++) begin
      cyc = 1; stb = 1; we = 1; adr = 32'h8; sel = 4'hF; bte = 2'b01;
      dat_ms = 32'h5000_0000 + k;
      cti = (k == 3) ? 3'b111 : 3'b010;
      @(negedge clk);
      chk($sformatf("wburst_ack%0d", k), ack, 1);
      nxt();
    end
    idle_bus();
    model[2] = 32'h5000_0000; model[3] = 32'h5000_0001;
    model[0] = 32'h5000_0002; model[1] = 32'h5000_0003;
    rd_classic("wb_r0", 32'h0, 32'h5000_0002);
    rd_classic("wb_r3", 32'hC, 32'h5000_0001);

    // Unsupported cti behaves as classic: single ack even with stb held.
    cyc = 1; stb = 1; we = 0; adr = 32'h14; sel = 4'hF; cti = 3'b011; bte = 2'b00;
    @(negedge clk); chk("cti3_first", ack, 0); nxt();
    @(negedge clk); chk("cti3_ack", ack, 1); chk("cti3_dat", dat_sm, 32'hC0DE_0005); nxt();
    @(negedge clk); chk("cti3_single", ack, 0); nxt();
    idle_bus();
    @(negedge clk); chk("cti3_idle", ack, 0); nxt();

    // Out-of-range write: err same cycle, memory untouched.
    cyc = 1; stb = 1; we = 1; adr = 32'h2010; sel = 4'hF; dat_ms = 32'hBADBAD00; cti = 3'b000;
    @(negedge clk); chk("oorw_err", err, 1); chk("oorw_ack", ack, 0); nxt();
    idle_bus();
    rd_classic("oorw_mem", 32'h10, 32'h11BB33DD);

    // Out-of-range read: err one cycle later, never ack.
    cyc = 1; stb = 1; we = 0; adr = 32'h2010; sel = 4'hF; cti = 3'b000;
    @(negedge clk); chk("oorr_err0", err, 0); chk("oorr_ack0", ack, 0); nxt();
    @(negedge clk); chk("oorr_err1", err, 1); chk("oorr_ack1", ack, 0); nxt();
    idle_bus();
    @(negedge clk); chk("oorr_err2", err, 0); chk("oorr_ack2", ack, 0); nxt();

    // we rises mid-burst: burst ends, write handled as a first beat.
    cyc = 1; stb = 1; we = 0; adr = 32'h20; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    @(negedge clk); chk("wemid_first", ack, 0); nxt();
    @(negedge clk); chk("wemid_ack0", ack, 1); chk("wemid_dat0", dat_sm, 32'hC0DE_0008); nxt();
    we = 1; adr = 32'h24; dat_ms = 32'h7777_0009; cti = 3'b000;
    @(negedge clk); chk("wemid_wack", ack, 1); chk("wemid_werr", err, 0); nxt();
    idle_bus();
    @(negedge clk); chk("wemid_idle", ack, 0); nxt();
    model[9] = 32'h7777_0009;
    rd_classic("wemid_rd", 32'h24, 32'h7777_0009);

    // Reset during beat 2 of an 8-beat burst.
    cyc = 1; stb = 1; we = 0; adr = 32'h0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    @(negedge clk); chk("rstb_first", ack, 0); nxt();
    @(negedge clk); chk("rstb_ack0", ack, 1); nxt();
    @(negedge clk); chk("rstb_ack1", ack, 1);
    #1 rst_n = 0;
    #1;
    chk("rstb_ack", ack, 0);
    chk("rstb_err", err, 0);
    chk("rstb_dat", dat_sm, 0);
    nxt();
    @(negedge clk); chk("rstb_hold", ack, 0);
    nxt();
    idle_bus();
    rst_n = 1;
    rd_classic("rstb_rd", 32'h14, 32'hC0DE_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
